// File: rtl/ws2812b_receiver_if.sv
// Output bundle of the WS2812B receiver.
//   master : driven by the receiver (decoded pixels, frame and error strobes)
//   slave  : consumed by whatever monitors the decoded stream
// Ports:
//   pixel_valid       one-cycle strobe, pixel_* carry a new LED word
//   pixel_led_number  LED index within the frame, 0 = first after latch
//   pixel_red/green/blue  8-bit intensities
//   frame_done        one-cycle strobe at the latch that ends a non-empty frame
//   frame_count       complete words in that frame, valid with frame_done
//   bit_error         one-cycle strobe on a timing violation or partial word
interface ws2812b_receiver_if #(
    parameter int MAX_POS = 16
);
    localparam int IDX_W = $clog2(MAX_POS);

    logic             pixel_valid;
    logic [IDX_W-1:0] pixel_led_number;
    logic [7:0]       pixel_red;
    logic [7:0]       pixel_green;
    logic [7:0]       pixel_blue;
    logic             frame_done;
    logic [IDX_W:0]   frame_count;
    logic             bit_error;

    modport master (
        output pixel_valid, pixel_led_number, pixel_red, pixel_green, pixel_blue,
        output frame_done, frame_count, bit_error
    );

    modport slave (
        input pixel_valid, pixel_led_number, pixel_red, pixel_green, pixel_blue,
        input frame_done, frame_count, bit_error
    );
endinterface

// File: rtl/ws2812b_receiver.sv
// WS2812B NRZ stream decoder.
// Measures the high time of each pulse on leds_line, decodes it to a bit,
// assembles 24-bit GRB words into per-LED pixels and detects the latch low
// period that ends a frame.
// Ports:
//   clk        system clock (50 MHz)
//   reset      synchronous, active-high
//   leds_line  asynchronous NRZ data line
//   px         decoded pixel / frame / error outputs (master side)
module ws2812b_receiver #(
    parameter int MAX_POS       = 16,
    parameter int BIT_THRESHOLD = 29,
    parameter int MIN_HIGH      = 8,
    parameter int MAX_HIGH      = 55,
    parameter int RESET_LOW     = 2500
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                leds_line,
    ws2812b_receiver_if.master  px
);
    localparam int IDX_W  = $clog2(MAX_POS);
    localparam int CNT_W  = IDX_W + 1;
    localparam int HIGH_W = $clog2(MAX_HIGH + 2);
    localparam int LOW_W  = $clog2(RESET_LOW + 1);

    localparam logic [HIGH_W-1:0] MAX_HIGH_C  = HIGH_W'(MAX_HIGH);
    localparam logic [HIGH_W-1:0] MIN_HIGH_C  = HIGH_W'(MIN_HIGH);
    localparam logic [HIGH_W-1:0] THRESH_C    = HIGH_W'(BIT_THRESHOLD);
    localparam logic [LOW_W-1:0]  RESET_LOW_C = LOW_W'(RESET_LOW);
    localparam logic [CNT_W-1:0]  MAX_POS_C   = CNT_W'(MAX_POS);

    typedef enum logic [1:0] {
        S_SYNC,
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t            state;
    logic              sync1;
    logic              line_s;
    logic              line_q;
    logic [HIGH_W-1:0] high_cnt;
    logic [LOW_W-1:0]  low_cnt;
    logic [4:0]        bit_cnt;
    logic [22:0]       shreg;      // first 23 bits of the word in flight
    logic [CNT_W-1:0]  word_idx;   // saturates at MAX_POS
    logic              word_pend;  // completed word waiting to be presented
    logic [23:0]       word_q;
    logic [IDX_W-1:0]  idx_q;

    logic        rise;
    logic        fall;
    logic [23:0] new_word;

    assign rise     = line_s & ~line_q;
    assign fall     = ~line_s & line_q;
    // Word as it stands once the bit ending on this fall is shifted in.
    assign new_word = {shreg, (high_cnt > THRESH_C)};

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= S_SYNC;
            sync1               <= 1'b0;
            line_s              <= 1'b0;
            line_q              <= 1'b0;
            high_cnt            <= '0;
            low_cnt             <= '0;
            bit_cnt             <= '0;
            shreg               <= '0;
            word_idx            <= '0;
            word_pend           <= 1'b0;
            word_q              <= '0;
            idx_q               <= '0;
            px.pixel_valid      <= 1'b0;
            px.pixel_led_number <= '0;
            px.pixel_red        <= '0;
            px.pixel_green      <= '0;
            px.pixel_blue       <= '0;
            px.frame_done       <= 1'b0;
            px.frame_count      <= '0;
            px.bit_error        <= 1'b0;
        end else begin
            sync1  <= leds_line;
            line_s <= sync1;
            line_q <= line_s;

            px.pixel_valid <= 1'b0;
            px.frame_done  <= 1'b0;
            px.bit_error   <= 1'b0;

            // A word completed on the previous clock is presented now; this
            // extra stage gives the fixed 3-edge latency from the last fall.
            if (word_pend) begin
                word_pend           <= 1'b0;
                px.pixel_valid      <= 1'b1;
                px.pixel_led_number <= idx_q;
                px.pixel_green      <= word_q[23:16];
                px.pixel_red        <= word_q[15:8];
                px.pixel_blue       <= word_q[7:0];
            end

            case (state)
                // Wait for a full latch period before trusting the stream.
                S_SYNC: begin
                    if (low_cnt == RESET_LOW_C) begin
                        state   <= S_IDLE;
                        low_cnt <= '0;
                    end else if (line_s) begin
                        low_cnt <= '0;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (rise) begin
                        high_cnt <= 1;
                        bit_cnt  <= '0;
                        state    <= S_HIGH;
                    end
                end

                S_HIGH: begin
                    if (line_s) begin
                        if (high_cnt == MAX_HIGH_C) begin
                            px.bit_error <= 1'b1;
                            state        <= S_SYNC;
                            low_cnt      <= '0;
                            bit_cnt      <= '0;
                            word_idx     <= '0;
                        end else begin
                            high_cnt <= high_cnt + 1'b1;
                        end
                    end else if (fall) begin
                        if (high_cnt < MIN_HIGH_C) begin
                            px.bit_error <= 1'b1;
                            state        <= S_SYNC;
                            low_cnt      <= '0;
                            bit_cnt      <= '0;
                            word_idx     <= '0;
                        end else begin
                            shreg   <= new_word[22:0];
                            low_cnt <= 1;
                            state   <= S_LOW;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                // Words beyond MAX_POS are dropped silently.
                                if (word_idx < MAX_POS_C) begin
                                    word_pend <= 1'b1;
                                    word_q    <= new_word;
                                    idx_q     <= word_idx[IDX_W-1:0];
                                    word_idx  <= word_idx + 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end

                S_LOW: begin
                    if (low_cnt == RESET_LOW_C) begin
                        // Latch: close the frame. A partial word is an error;
                        // an error and frame_done may pulse together.
                        if (bit_cnt != 5'd0)
                            px.bit_error <= 1'b1;
                        if (word_idx != '0) begin
                            px.frame_done  <= 1'b1;
                            px.frame_count <= word_idx;
                        end
                        word_idx <= '0;
                        bit_cnt  <= '0;
                        low_cnt  <= '0;
                        state    <= S_IDLE;
                    end else if (rise) begin
                        high_cnt <= 1;
                        state    <= S_HIGH;
                    end else if (!line_s) begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                default: state <= S_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812b_receiver.sv
// Scoreboard bench for ws2812b_receiver: directed NRZ stimulus pushes the
// expected pixels / frame ends / errors into queues; a monitor pops and
// compares whenever the receiver strobes an output.
module tb_ws2812b_receiver;
    logic clk = 1'b0;
    logic reset;
    logic leds_line;

    always #10 clk = ~clk;

    ws2812b_receiver_if #(.MAX_POS(16)) ifc ();

    ws2812b_receiver #(.MAX_POS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .leds_line (leds_line),
        .px        (ifc)
    );

    typedef struct {
        int led;
        int r;
        int g;
        int b;
    } pix_t;

    typedef struct {
        int cnt;
        int err;
    } frm_t;

    pix_t pix_q[$];
    frm_t frm_q[$];
    int   err_q[$];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        fails++;
        $display("FAIL %s: strobe with nothing expected", name);
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        pix_t p;
        frm_t f;
        int   e;
        if (ifc.pixel_valid) begin
            if (pix_q.size() == 0) unexpected("pixel_valid");
            else begin
                p = pix_q.pop_front();
                chk("led_number", int'(ifc.pixel_led_number), p.led);
                chk("red",        int'(ifc.pixel_red),        p.r);
                chk("green",      int'(ifc.pixel_green),      p.g);
                chk("blue",       int'(ifc.pixel_blue),       p.b);
            end
        end
        if (ifc.frame_done) begin
            if (frm_q.size() == 0) unexpected("frame_done");
            else begin
                f = frm_q.pop_front();
                chk("frame_count",      int'(ifc.frame_count), f.cnt);
                chk("frame_err_cycle",  int'(ifc.bit_error),   f.err);
            end
        end
        if (ifc.bit_error) begin
            if (err_q.size() == 0) unexpected("bit_error");
            else e = err_q.pop_front();
        end
    end

    task automatic push_pix(input int led, input int g, input int r, input int b);
        pix_t p;
        p.led = led; p.g = g; p.r = r; p.b = b;
        pix_q.push_back(p);
    endtask

    task automatic push_word(input int led, input logic [23:0] w);
        push_pix(led, int'(w[23:16]), int'(w[15:8]), int'(w[7:0]));
    endtask

    task automatic push_frame(input int cnt, input int err);
        frm_t f;
        f.cnt = cnt; f.err = err;
        frm_q.push_back(f);
    endtask

    task automatic hold(input logic v, input int n);
        leds_line = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_hi(input int h);
        hold(1'b1, h);
        hold(1'b0, 62 - h);
    endtask

    // fast: short low time, used for bulk frames where only content matters
    task automatic send_bit(input logic b, input bit fast);
        hold(1'b1, b ? 39 : 19);
        hold(1'b0, fast ? 12 : (b ? 23 : 43));
    endtask

    task automatic send_bits(input logic [23:0] w, input int n, input bit fast);
        for (int i = 23; i > 23 - n; i--) send_bit(w[i], fast);
    endtask

    task automatic send_word(input logic [23:0] w, input bit fast);
        send_bits(w, 24, fast);
    endtask

    initial begin
        logic [23:0] w;
        logic [7:0]  n8;
        int          h;

        reset     = 1'b1;
        leds_line = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_pixel_valid", int'(ifc.pixel_valid),      0);
        chk("rst_led_number",  int'(ifc.pixel_led_number), 0);
        chk("rst_rgb",         int'({ifc.pixel_red, ifc.pixel_green, ifc.pixel_blue}), 0);
        chk("rst_frame",       int'({ifc.frame_done, ifc.frame_count}), 0);
        chk("rst_bit_error",   int'(ifc.bit_error),        0);
        reset = 1'b0;

        // Single word after the initial latch period.
        hold(1'b0, 2510);
        push_pix(0, 8'hA5, 8'h3C, 8'h0F);
        push_frame(1, 0);
        send_word(24'hA53C0F, 1'b0);
        hold(1'b0, 2600);

        // Full 16-word frame, then 17 words with the last dropped.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16 + k; i++) begin
                n8 = 8'(i);
                w  = {n8, ~n8, n8 ^ 8'h55};
                if (i < 16) push_word(i, w);
                send_word(w, 1'b1);
            end
            push_frame(16, 0);
            hold(1'b0, 2520);
        end

        // Threshold and limit highs: 55->1, 8->0, 30->1, 29->0.
        w = 24'hC35A96;
        push_pix(0, 8'hC3, 8'h5A, 8'h96);
        push_frame(1, 0);
        for (int i = 23; i >= 0; i--) begin
            h = w[i] ? 30 : 29;
            if (i == 23) h = 55;
            if (i == 21) h = 8;
            send_hi(h);
        end
        hold(1'b0, 2520);
        // 7-clock glitch, following bits ignored until a full latch.
        err_q.push_back(1);
        send_hi(7);
        send_bits(24'hFFFFFF, 8, 1'b1);
        hold(1'b0, 2520);
        push_pix(0, 8'h12, 8'h34, 8'h56);
        push_frame(1, 0);
        send_word(24'h123456, 1'b0);
        hold(1'b0, 2520);

        // Stuck-high after one word aborts the frame (no frame_done).
        push_pix(0, 8'hFF, 8'h80, 8'h01);
        send_word(24'hFF8001, 1'b0);
        err_q.push_back(1);
        hold(1'b1, 56);
        hold(1'b0, 10);
        send_bits(24'hA5A5A5, 8, 1'b1);
        hold(1'b0, 2520);
        push_pix(0, 8'h00, 8'hFF, 8'h00);
        push_frame(1, 0);
        send_word(24'h00FF00, 1'b0);
        hold(1'b0, 2520);

        // Partial word with no complete words: error only.
        err_q.push_back(1);
        send_bits(24'hABCDEF, 10, 1'b0);
        hold(1'b0, 2520);
        // Two words plus partial: error and frame_done together.
        push_pix(0, 8'h11, 8'h11, 8'h11);
        push_pix(1, 8'h22, 8'h22, 8'h22);
        push_frame(2, 1);
        err_q.push_back(1);
        send_word(24'h111111, 1'b0);
        send_word(24'h222222, 1'b0);
        send_bits(24'hF0F0F0, 5, 1'b0);
        hold(1'b0, 2520);

        // Reset mid-frame, then a frame with no preceding latch is ignored.
        for (int i = 0; i < 3; i++) begin
            w = {8'hA0, 8'(i), 8'(3 * i + 1)};
            push_word(i, w);
            send_word(w, 1'b1);
        end
        send_bits(24'h3C3C3C, 12, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send_word(24'h777777, 1'b1);
        hold(1'b0, 2520);
        push_pix(0, 8'h0A, 8'h0B, 8'h0C);
        push_frame(1, 0);
        send_word(24'h0A0B0C, 1'b0);
        hold(1'b0, 2520);

        repeat (20) @(negedge clk);
        chk("pixels_missing", pix_q.size(), 0);
        chk("frames_missing", frm_q.size(), 0);
        chk("errors_missing", err_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
